// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, types and helpers for the display scan controller
package display_pkg;

    localparam logic [6:0] DIGIT_SEGS [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [8:0] SEG_OFF   = 9'h1FF;
    localparam logic [6:0] SPEED_MAX = 7'd99;

    // Select field is segs[11:9] = {pos2, pos1, pos0}, active-low
    localparam logic [2:0] SEL_NONE = 3'b111;
    localparam logic [2:0] SEL_POS0 = 3'b110;
    localparam logic [2:0] SEL_POS1 = 3'b101;
    localparam logic [2:0] SEL_POS2 = 3'b011;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } scan_state_t;

    typedef logic [1:0] pos_t;
    localparam pos_t POS0 = 2'd0;
    localparam pos_t POS1 = 2'd1;
    localparam pos_t POS2 = 2'd2;

    function automatic logic [6:0] sat_speed(input logic [6:0] s);
        return (s > SPEED_MAX) ? SPEED_MAX : s;
    endfunction

    function automatic logic [6:0] digit_code(input logic [3:0] d);
        if (d <= 4'd9) return DIGIT_SEGS[d];
        return 7'h7F;
    endfunction

endpackage

// File: rtl/speed_bin2bcd.sv
// rtl/speed_bin2bcd.sv - sequential shift-add-3 converter, saturating 7-bit speed to two BCD digits
module speed_bin2bcd
    import display_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    input  logic [6:0] i_bin,
    output logic       o_ready,
    output logic       o_done,
    output logic [3:0] o_tens,
    output logic [3:0] o_units
);

    // r_sr = {tens, units, binary}; steps 0..6 shift, step 7 presents the result, step 8 releases
    logic        r_busy;
    logic [3:0]  r_step;
    logic [14:0] r_sr;
    logic [14:0] w_adj;

    always_comb begin
        w_adj = r_sr;
        if (w_adj[10:7] >= 4'd5)  w_adj[10:7]  = w_adj[10:7] + 4'd3;
        if (w_adj[14:11] >= 4'd5) w_adj[14:11] = w_adj[14:11] + 4'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_step <= '0;
            r_sr   <= '0;
        end else if (!r_busy) begin
            if (i_valid) begin
                r_busy <= 1'b1;
                r_step <= '0;
                r_sr   <= {8'd0, sat_speed(i_bin)};
            end
        end else begin
            r_step <= r_step + 4'd1;
            if (r_step < 4'd7)  r_sr   <= {w_adj[13:0], 1'b0};
            if (r_step == 4'd8) r_busy <= 1'b0;
        end
    end

    assign o_ready = ~r_busy;
    assign o_done  = r_busy && (r_step == 4'd7);
    assign o_tens  = r_sr[14:11];
    assign o_units = r_sr[10:7];

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 3-position display scan with blanking and frame-aligned speed digits
// Optional: LEADING_ZERO_BLANK_EN darkens pos1 when the displayed tens digit is 0.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        on,
    input  logic [8:0]  sym_segs,
    input  logic [6:0]  speed,
    input  logic        speed_valid,
    output logic        speed_ready,
    output logic        frame_start,
    output logic [11:0] segs
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    scan_state_t      r_state, w_state_nxt;
    pos_t             r_pos, w_pos_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic        r_frame_start;
    logic [11:0] r_segs;
    logic [3:0]  r_pend_tens, r_pend_units, r_disp_tens, r_disp_units;
    logic        w_frame;
    logic [11:0] w_segs_nxt;
    logic        w_done;
    logic [3:0]  w_tens, w_units;

    speed_bin2bcd u_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (speed_valid),
        .i_bin   (speed),
        .o_ready (speed_ready),
        .o_done  (w_done),
        .o_tens  (w_tens),
        .o_units (w_units)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
            r_pos   <= POS0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_frame     = 1'b0;
        w_segs_nxt  = {SEL_NONE, SEG_OFF};
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHOW: begin
                w_frame = (r_pos == POS0) && (r_cnt == '0);
                case (r_pos)
                    POS0: w_segs_nxt = {SEL_POS0, sym_segs};
                    POS1: begin
`ifdef LEADING_ZERO_BLANK_EN
                        if (r_disp_tens == 4'd0) w_segs_nxt = {SEL_POS1, SEG_OFF};
                        else                     w_segs_nxt = {SEL_POS1, 2'b11, digit_code(r_disp_tens)};
`else
                        w_segs_nxt = {SEL_POS1, 2'b11, digit_code(r_disp_tens)};
`endif
                    end
                    default: w_segs_nxt = {SEL_POS2, 2'b11, digit_code(r_disp_units)};
                endcase
                if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_pos_nxt   = (r_pos == POS2) ? POS0 : r_pos + 2'd1;
                end
            end
            default: w_state_nxt = ST_BLANK;
        endcase
        // Display off parks the scan at its reset point so it restarts cleanly
        if (!on) begin
            w_state_nxt = ST_BLANK;
            w_pos_nxt   = POS0;
            w_cnt_nxt   = '0;
            w_frame     = 1'b0;
            w_segs_nxt  = {SEL_NONE, SEG_OFF};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segs        <= 12'hFFF;
            r_frame_start <= 1'b0;
            r_pend_tens   <= '0;
            r_pend_units  <= '0;
            r_disp_tens   <= '0;
            r_disp_units  <= '0;
        end else begin
            r_segs        <= w_segs_nxt;
            r_frame_start <= w_frame;
            if (w_done) begin
                r_pend_tens  <= w_tens;
                r_pend_units <= w_units;
            end
            // Digits change only at a frame boundary so a frame never mixes old and new values
            if (w_frame) begin
                r_disp_tens  <= r_pend_tens;
                r_disp_units <= r_pend_units;
            end
        end
    end

    assign segs        = r_segs;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed scoreboard bench for display_scan_ctrl (REFRESH_DIV=4, BLANK_CYCLES=1)
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        on;
    logic [8:0]  sym_segs;
    logic [6:0]  speed;
    logic        speed_valid;
    logic        speed_ready;
    logic        frame_start;
    logic [11:0] segs;

    int total = 0;
    int bad   = 0;
    int q_speed[$];
    int cur_t = 0;
    int cur_u = 0;

    display_scan_ctrl #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .on          (on),
        .sym_segs    (sym_segs),
        .speed       (speed),
        .speed_valid (speed_valid),
        .speed_ready (speed_ready),
        .frame_start (frame_start),
        .segs        (segs)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected pin value at offset i (0..14) within a frame, i=0 being the frame_start cycle
    function automatic logic [11:0] exp_segs(input int i, input int t, input int u);
        if (i < 4) return {3'b110, sym_segs};
        if (i == 4 || i == 9 || i == 14) return 12'hFFF;
        if (i < 9) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (t == 0) return {3'b101, 9'h1FF};
`endif
            return {3'b101, 2'b11, seg7(t)};
        end
        return {3'b011, 2'b11, seg7(u)};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        while (frame_start !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("frame_wait", 12'(frame_start), 12'd1);
    endtask

    // Called on the negedge where frame_start is high; returns on the next one
    task automatic check_frame(input int t, input int u);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("segs[%0d] t=%0d u=%0d", i, t, u), segs, exp_segs(i, t, u));
            chk($sformatf("fs[%0d]", i), 12'(frame_start), (i == 0) ? 12'd1 : 12'd0);
            @(negedge clk);
        end
        chk("frame_period", 12'(frame_start), 12'd1);
        cur_t = t;
        cur_u = u;
    endtask

    task automatic check_frame_pop();
        int v;
        total++;
        assert (q_speed.size() > 0)
        else begin
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        v = (q_speed.size() > 0) ? q_speed.pop_front() : 0;
        check_frame(v / 10, v % 10);
    endtask

    function automatic int model_sat(input int s);
        return (s > 99) ? 99 : s;
    endfunction

    task automatic offer_and_wait(input int s);
        int n = 0;
        chk("ready_before_offer", 12'(speed_ready), 12'd1);
        speed       = 7'(s);
        speed_valid = 1'b1;
        q_speed.push_back(model_sat(s));
        @(negedge clk);
        speed_valid = 1'b0;
        while (speed_ready === 1'b0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 12'(n), 12'd9);
    endtask

    initial begin
        rst_n       = 1'b0;
        on          = 1'b1;
        sym_segs    = 9'h0AA;
        speed       = 7'd0;
        speed_valid = 1'b0;

        // 1: reset state, startup latency, first frames with zero digits
        repeat (2) @(negedge clk);
        chk("rst_segs", segs, 12'hFFF);
        chk("rst_ready", 12'(speed_ready), 12'd1);
        chk("rst_fs", 12'(frame_start), 12'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("startup_blank", segs, 12'hFFF);
        chk("startup_fs0", 12'(frame_start), 12'd0);
        @(negedge clk);
        chk("startup_fs1", 12'(frame_start), 12'd1);
        check_frame(0, 0);

        // 2: speed 57
        offer_and_wait(57);
        wait_frame();
        check_frame_pop();

        // 3: speed 120 saturates to 99, with a new symbol pattern
        sym_segs = 9'h155;
        offer_and_wait(120);
        wait_frame();
        check_frame_pop();

        // 4: 4 accepted, 42 held while busy, each lands on its own frame
        wait_frame();
        chk("ready_before_4", 12'(speed_ready), 12'd1);
        speed       = 7'd4;
        speed_valid = 1'b1;
        q_speed.push_back(model_sat(4));
        @(negedge clk);
        chk("busy_after_4", 12'(speed_ready), 12'd0);
        speed = 7'd42;
        q_speed.push_back(model_sat(42));
        wait_frame();
        check_frame_pop();
        speed_valid = 1'b0;
        check_frame_pop();

        // 5: display off during SHOW1, then back on
        repeat (6) @(negedge clk);
        on = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("off_segs[%0d]", i), segs, 12'hFFF);
            chk($sformatf("off_fs[%0d]", i), 12'(frame_start), 12'd0);
        end
        on = 1'b1;
        @(negedge clk);
        chk("on_blank", segs, 12'hFFF);
        chk("on_fs0", 12'(frame_start), 12'd0);
        @(negedge clk);
        chk("on_fs1", 12'(frame_start), 12'd1);
        check_frame(cur_t, cur_u);

        // 6: reset three cycles into a conversion discards it and clears digits
        chk("ready_before_77", 12'(speed_ready), 12'd1);
        speed       = 7'd77;
        speed_valid = 1'b1;
        @(negedge clk);
        speed_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_segs", segs, 12'hFFF);
        chk("async_rst_ready", 12'(speed_ready), 12'd1);
        chk("async_rst_fs", 12'(frame_start), 12'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        wait_frame();
        check_frame(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
